mem_req_arbiter: RTL
====================

// Module: mem_req_arbiter
// PURPOSE
// - Shares one memory port (req_val/req_addr/req_ID -> rsp_val/rsp_ID/rsp_data) between NREQ requesters.
// - Round-robin arbitration; allocates a free transaction ID (tag) per accepted request.
// - Records which requester owns each ID; routes out-of-order responses back to that requester.
// - Sits between the ROB-side load requesters and the memory model/port.
// PARAMETERS
// - NREQ    4                    number of requesters (>=2)
// - AWIDTH  rob_package::AWIDTH  address width
// - SWIDTH  rob_package::SWIDTH  ID width; pool size NID = 2**SWIDTH
// - DWIDTH  rob_package::DWIDTH  response data width
// PORTS
// - clk           in   1               clock, all logic on rising edge
// - rst_n         in   1               asynchronous reset, active low
// - rq_val        in   NREQ            requester i has a request
// - rq_addr       in   NREQ*AWIDTH     request address, slice i = [i*AWIDTH +: AWIDTH]
// - rq_rdy        out  NREQ            request i accepted this cycle (one-hot or zero)
// - rs_val        out  NREQ            response for requester i (one-hot or zero)
// - rs_data       out  DWIDTH          response data, qualified by rs_val
// - mem_req_val   out  1               memory request valid
// - mem_req_addr  out  AWIDTH          memory request address
// - mem_req_ID    out  SWIDTH          memory request ID
// - mem_rsp_val   in   1               memory response valid
// - mem_rsp_ID    in   SWIDTH          memory response ID
// - mem_rsp_data  in   DWIDTH          memory response data
// - out_cnt       out  SWIDTH+1        number of IDs outstanding (0..NID)
// - err_rsp       out  1               sticky error (only with MEM_ARB_RSP_CHECK_EN)
// BEHAVIOUR
// - Reset: all outputs 0; busy[] all 0; owner[] 0; rr pointer 0; out_cnt 0.
// - Arbitration (combinational): if out_cnt<NID, grant the first rq_val[j] scanning from rr pointer
//   upward mod NREQ; rq_rdy = grant. Pool full -> rq_rdy all 0. Requesters hold val/addr until rdy.
// - Handshake rq_val[i]&rq_rdy[i]: allocate lowest-index free ID k; busy[k]<=1; owner[k]<=i;
//   rr pointer <= (i+1) mod NREQ. No handshake -> pointer unchanged.
// - Memory request registered, latency 1: cycle after handshake mem_req_val=1, mem_req_addr=rq_addr[i],
//   mem_req_ID=k; mem_req_val=0 otherwise. Max one request per cycle; memory port has no backpressure.
// - Response: mem_rsp_val with busy[mem_rsp_ID]=1 -> next cycle rs_val[owner]=1, rs_data=mem_rsp_data;
//   busy[mem_rsp_ID]<=0. rs_data holds last value when rs_val=0.
// - Freed ID allocatable from the cycle after the response (no same-cycle reuse).
// - Simultaneous alloc and free: both apply; out_cnt unchanged; when full, the free makes rq_rdy
//   possible next cycle, not this one.
// - out_cnt: +1 on handshake, -1 on valid response, registered; never exceeds NID, never wraps.
// - Response for non-busy ID: dropped, no rs_val, no state change.
// - Reset mid-operation: all IDs freed immediately; late responses for pre-reset IDs are dropped by
//   the non-busy rule, or misrouted if that ID has been reallocated (memory side is reset together).
// CONFIGURATION
// - MEM_ARB_RSP_CHECK_EN defined: err_rsp present; set on response for non-busy ID; cleared only by
//   rst_n. Also set by a handshake with rq_addr containing X (simulation only).
// - Not defined: port err_rsp absent; bad responses silently dropped; no extra logic.
// TESTING
// - Single: rq_val[2]=1, addr 0x40 -> rq_rdy[2] same cycle; next cycle mem_req_val=1 addr 0x40 ID 0;
//   rsp ID 0 data 0xA5 -> next cycle rs_val=4'b0100, rs_data=0xA5; out_cnt 1->0.
// - Round robin: rq_val=4'b1111 held 8 cycles, no responses -> grants 0,1,2,3,0,1,2,3; IDs 0..7.
// - Full pool: NID requests issued, no responses -> rq_rdy=0, out_cnt=NID; rsp ID 5 -> next handshake
//   is one cycle later and allocates ID 5.
// - Out of order: IDs 0(req1),1(req3),2(req0) issued; rsps 2,0,1 -> rs_val 0001,0010,1000 in order.
// - Simultaneous: full pool, rsp ID 3 in same cycle a request waits -> accepted next cycle with ID 3,
//   out_cnt stays NID.
// - Error/reset: rsp for free ID 7 -> no rs_val, err_rsp=1 (with MEM_ARB_RSP_CHECK_EN);
//   rst_n low with 3 outstanding -> out_cnt=0, all outputs 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one memory port between NREQ load requesters. A combinational
//   round-robin arbiter picks one requester per cycle. Each accepted request
//   gets the lowest free transaction ID, and the arbiter records the owning
//   requester for that ID. The request is forwarded to memory one cycle later.
//   Responses can return out of order; each is routed back to the requester
//   that owns its ID, and the ID is then released.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   rq_val/rq_addr   per-requester request valid and address (slice i = [i*AWIDTH +: AWIDTH])
//   rq_rdy           one-hot (or zero) accept, combinational from rq_val
//   rs_val/rs_data   one-hot response strobe to the owning requester, plus data
//   mem_req_*        registered request to memory (no backpressure)
//   mem_rsp_*        response from memory, tagged with the request ID
//   out_cnt          number of IDs currently outstanding (0..2**SWIDTH)
//   err_rsp          sticky bad-response flag (MEM_ARB_RSP_CHECK_EN builds only)
//
// Build option
//   MEM_ARB_RSP_CHECK_EN : adds err_rsp. The flag sets when a response arrives
//                          for an ID that is not busy. In simulation it also
//                          sets when a request is accepted with an X address.
//                          Without this macro, bad responses are dropped silently.

module mem_req_arbiter #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 32,
  parameter int SWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          rq_val,
  input  logic [NREQ*AWIDTH-1:0]   rq_addr,
  output logic [NREQ-1:0]          rq_rdy,
  output logic [NREQ-1:0]          rs_val,
  output logic [DWIDTH-1:0]        rs_data,
  output logic                     mem_req_val,
  output logic [AWIDTH-1:0]        mem_req_addr,
  output logic [SWIDTH-1:0]        mem_req_ID,
  input  logic                     mem_rsp_val,
  input  logic [SWIDTH-1:0]        mem_rsp_ID,
  input  logic [DWIDTH-1:0]        mem_rsp_data,
  output logic [SWIDTH:0]          out_cnt
`ifdef MEM_ARB_RSP_CHECK_EN
  ,
  output logic                     err_rsp
`endif
);

  localparam int NID = 1 << SWIDTH;
  localparam int RW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [SWIDTH:0] NID_CNT = {1'b1, {SWIDTH{1'b0}}};
  localparam logic [SWIDTH:0] CNT_ONE = {{SWIDTH{1'b0}}, 1'b1};

  logic [NID-1:0]    busy_r;
  logic [NID-1:0]    busy_nxt_s;
  logic [RW-1:0]     owner_r [NID];
  logic [RW-1:0]     rr_r;
  logic              full_s;
  logic              hs_s;
  logic              rsp_ok_s;
  logic [NREQ-1:0]   grant_s;
  logic [RW-1:0]     gidx_s;
  logic [SWIDTH-1:0] free_id_s;
  logic [AWIDTH-1:0] gaddr_s;

  // Requester index (base + off) modulo NREQ.
  function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return sum[RW-1:0];
  endfunction

  // The pool is full exactly when every ID is outstanding.
  // A free in this cycle only takes effect on out_cnt next cycle.
  assign full_s   = (out_cnt == NID_CNT);
  assign rsp_ok_s = mem_rsp_val & busy_r[mem_rsp_ID];
  assign rq_rdy   = grant_s;
  assign gaddr_s  = rq_addr[gidx_s*AWIDTH +: AWIDTH];

  // Round-robin pick: first valid requester at or after the rr pointer.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    hs_s    = 1'b0;
    if (!full_s) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hs_s && rq_val[wrap_add(rr_r, i)]) begin
          grant_s[wrap_add(rr_r, i)] = 1'b1;
          gidx_s                     = wrap_add(rr_r, i);
          hs_s                       = 1'b1;
        end else begin
          hs_s = hs_s;
        end
      end
    end else begin
      hs_s = 1'b0;
    end
  end

  // Lowest-index free ID. The scan runs downward, so the last hit is the lowest.
  always_comb begin
    free_id_s = '0;
    for (int k = NID - 1; k >= 0; k--) begin
      if (!busy_r[k]) begin
        free_id_s = SWIDTH'(k);
      end else begin
        free_id_s = free_id_s;
      end
    end
  end

  // Next busy vector. The allocated ID is free and the responding ID is busy,
  // so the two updates never hit the same bit.
  always_comb begin
    busy_nxt_s = busy_r;
    if (hs_s) begin
      busy_nxt_s[free_id_s] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (rsp_ok_s) begin
      busy_nxt_s[mem_rsp_ID] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // ID pool, owner table, rr pointer and outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= '0;
      rr_r    <= '0;
      out_cnt <= '0;
      for (int k = 0; k < NID; k++) begin
        owner_r[k] <= '0;
      end
    end else begin
      busy_r <= busy_nxt_s;
      if (hs_s) begin
        owner_r[free_id_s] <= gidx_s;
        rr_r               <= wrap_add(gidx_s, 1);
      end
      case ({hs_s, rsp_ok_s})
        2'b10:   out_cnt <= out_cnt + CNT_ONE;
        2'b01:   out_cnt <= out_cnt - CNT_ONE;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Registered memory request, issued one cycle after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_val  <= 1'b0;
      mem_req_addr <= '0;
      mem_req_ID   <= '0;
    end else begin
      mem_req_val <= hs_s;
      if (hs_s) begin
        mem_req_addr <= gaddr_s;
        mem_req_ID   <= free_id_s;
      end
    end
  end

  // Route a valid response to its owner. rs_data holds its value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_val  <= '0;
      rs_data <= '0;
    end else begin
      rs_val <= '0;
      if (rsp_ok_s) begin
        rs_val[owner_r[mem_rsp_ID]] <= 1'b1;
        rs_data                     <= mem_rsp_data;
      end
    end
  end

`ifdef MEM_ARB_RSP_CHECK_EN
  logic addr_x_s;
`ifdef SYNTHESIS
  assign addr_x_s = 1'b0;
`else
  assign addr_x_s = hs_s && $isunknown(gaddr_s);
`endif

  // Sticky error flag; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_rsp <= 1'b0;
    end else if ((mem_rsp_val && !busy_r[mem_rsp_ID]) || addr_x_s) begin
      err_rsp <= 1'b1;
    end
  end
`endif

endmodule
